// File: rtl/uvmf_hdl_xact_mux_pkg_hdl.sv
// Shared types and helpers for the multi-channel transaction mux buffer.
// No logic here: enums for arbitration mode and output-stage state, plus a clog2 floor of 1.
package uvmf_hdl_xact_mux_pkg_hdl;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } out_state_e;

  // Channel tag needs at least one bit even with a single channel.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uvmf_hdl_sync_fifo.sv
// Single-channel show-ahead FIFO; dout valid the cycle after a push into an empty FIFO.
// Pushes while full and pops while empty are ignored; clear/reset empty it in one cycle.
module uvmf_hdl_sync_fifo #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 8,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A write during clear lands at an entry that the reset pointers treat as empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/uvmf_hdl_xact_mux_buffer.sv
// Per-channel FIFOs merged onto one registered, channel-tagged valid/ready output; 2-cycle empty-path latency.
// in_ready depends only on registered FIFO counts; the output register holds stable while out_ready is low.
module uvmf_hdl_xact_mux_buffer
  import uvmf_hdl_xact_mux_pkg_hdl::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 8,
  parameter  int NUM_CH     = 4,
  parameter  int ARB_MODE   = 0,
  localparam int CH_W       = clog2_min1(NUM_CH),
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]              out_ch,
  output logic [NUM_CH*(AW+1)-1:0]     ch_count,
  output logic [NUM_CH-1:0]            stall_sticky
);

  logic [NUM_CH-1:0]     full;
  logic [NUM_CH-1:0]     empty;
  logic [NUM_CH-1:0]     push;
  logic [NUM_CH-1:0]     pop;
  logic [AW:0]           count [NUM_CH];
  logic [DATA_WIDTH-1:0] dout  [NUM_CH];
  logic [CH_W-1:0]       grant;
  logic                  load;
  out_state_e            state;
  out_state_e            state_next;

  assign in_ready = reset ? '0 : ~full;
  assign push     = in_valid & in_ready;
  assign load     = !reset && !flush && (|(~empty)) && (state == EMPTY || out_ready);

  always_comb begin
    pop = '0;
    if (load) pop[grant] = 1'b1;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    uvmf_hdl_sync_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
    ) u_fifo (
      .clock(clock),
      .reset(reset),
      .clear(flush),
      .push (push[c]),
      .pop  (pop[c]),
      .din  (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .dout (dout[c]),
      .count(count[c]),
      .full (full[c]),
      .empty(empty[c])
    );
    assign ch_count[c*(AW+1) +: AW+1] = count[c];
  end

  if (NUM_CH == 1) begin : g_single
    assign grant = '0;
  end else begin : g_arb
    logic [CH_W-1:0] rr_ptr;
    logic            found;
    int              idx;

    // Round-robin starts one past the last grant; fixed priority always starts at ch0.
    always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ARB_MODE == int'(ARB_FIXED)) idx = i;
        else                             idx = (int'(rr_ptr) + 1 + i) % NUM_CH;
        if (!found && !empty[idx]) begin
          found = 1'b1;
          grant = CH_W'(idx);
        end
      end
    end

    always_ff @(posedge clock) begin
      if (reset || flush) rr_ptr <= CH_W'(NUM_CH - 1);
      else if (load)      rr_ptr <= grant;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) state <= EMPTY;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (load)                          state_next = HELD;
    else if (state == HELD && out_ready) state_next = EMPTY;
  end

  always_comb begin
    out_valid = (state == HELD);
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      out_data <= '0;
      out_ch   <= '0;
    end else if (load) begin
      out_data <= dout[grant];
      out_ch   <= grant;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) stall_sticky <= '0;
    else                stall_sticky <= stall_sticky | (in_valid & ~in_ready);
  end

endmodule

// File: tb/tb_uvmf_hdl_xact_mux_buffer.sv
// Directed bench: a round-robin and a fixed-priority instance share every input.
// Each task drives one scenario and compares outputs against hand-computed values.
module tb_uvmf_hdl_xact_mux_buffer;
  localparam int DW = 32;
  localparam int NCH = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             flush;
  logic [NCH-1:0]   in_valid;
  logic [NCH*DW-1:0] in_data;
  logic             out_ready;

  logic [NCH-1:0] rr_in_ready, fx_in_ready;
  logic           rr_out_valid, fx_out_valid;
  logic [DW-1:0]  rr_out_data, fx_out_data;
  logic [1:0]     rr_out_ch, fx_out_ch;
  logic [15:0]    rr_ch_count, fx_ch_count;
  logic [NCH-1:0] rr_stall, fx_stall;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  uvmf_hdl_xact_mux_buffer #(.DATA_WIDTH(DW), .DEPTH(8), .NUM_CH(NCH), .ARB_MODE(0)) u_rr (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rr_in_ready),
    .in_data(in_data), .out_valid(rr_out_valid), .out_ready(out_ready), .out_data(rr_out_data),
    .out_ch(rr_out_ch), .ch_count(rr_ch_count), .stall_sticky(rr_stall));

  uvmf_hdl_xact_mux_buffer #(.DATA_WIDTH(DW), .DEPTH(8), .NUM_CH(NCH), .ARB_MODE(1)) u_fx (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(fx_in_ready),
    .in_data(in_data), .out_valid(fx_out_valid), .out_ready(out_ready), .out_data(fx_out_data),
    .out_ch(fx_out_ch), .ch_count(fx_ch_count), .stall_sticky(fx_stall));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_data(input int c, input logic [DW-1:0] v);
    in_data[c*DW +: DW] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 4'hF; out_ready = 1'b0; in_data = '0;
    step();
    step();
    checks++; if (rr_in_ready !== 4'h0 || fx_in_ready !== 4'h0) begin failures++;
      $display("FAIL reset_in_ready got rr=%h fx=%h want 0", rr_in_ready, fx_in_ready); end
    checks++; if (rr_out_valid !== 1'b0 || fx_out_valid !== 1'b0) begin failures++;
      $display("FAIL reset_out_valid got rr=%b fx=%b want 0", rr_out_valid, fx_out_valid); end
    checks++; if (rr_ch_count !== 16'h0 || fx_ch_count !== 16'h0) begin failures++;
      $display("FAIL reset_ch_count got rr=%h fx=%h want 0", rr_ch_count, fx_ch_count); end
    checks++; if (rr_stall !== 4'h0 || rr_out_data !== 32'h0 || rr_out_ch !== 2'd0) begin failures++;
      $display("FAIL reset_regs got stall=%h data=%h ch=%0d want 0", rr_stall, rr_out_data, rr_out_ch); end
    reset = 1'b0; in_valid = 4'h0;
    #1;
    checks++; if (rr_in_ready !== 4'hF) begin failures++;
      $display("FAIL release_in_ready got %h want f", rr_in_ready); end
  endtask

  task automatic test_latency();
    set_data(2, 32'hA5A5_0002); in_valid = 4'b0100; out_ready = 1'b1;
    step();
    in_valid = 4'h0;
    checks++; if (rr_out_valid !== 1'b0 || rr_ch_count[11:8] !== 4'd1) begin failures++;
      $display("FAIL lat_cycle1 got valid=%b cnt2=%0d want 0/1", rr_out_valid, rr_ch_count[11:8]); end
    step();
    checks++; if (rr_out_valid !== 1'b1 || rr_out_data !== 32'hA5A5_0002 || rr_out_ch !== 2'd2) begin failures++;
      $display("FAIL lat_cycle2 got valid=%b data=%h ch=%0d want 1/a5a50002/2", rr_out_valid, rr_out_data, rr_out_ch); end
    checks++; if (rr_ch_count[11:8] !== 4'd0 || fx_out_ch !== 2'd2) begin failures++;
      $display("FAIL lat_count got cnt2=%0d fx_ch=%0d want 0/2", rr_ch_count[11:8], fx_out_ch); end
    step();
    checks++; if (rr_out_valid !== 1'b0) begin failures++;
      $display("FAIL lat_drain got valid=%b want 0", rr_out_valid); end
  endtask

  task automatic test_arb();
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_ch;
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NCH; c++) set_data(c, DW'((c << 16) | k));
      in_valid = 4'hF;
      step();
    end
    in_valid = 4'h0;
    // ch0's first entry already sits in the output register.
    checks++; if (rr_ch_count !== 16'h2221 || fx_ch_count !== 16'h2221) begin failures++;
      $display("FAIL arb_preload got rr=%h fx=%h want 2221", rr_ch_count, fx_ch_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_ch = 2'(i % 4);
      exp_data = DW'(((i % 4) << 16) | (i / 4));
      checks++; if (rr_out_valid !== 1'b1 || rr_out_ch !== exp_ch || rr_out_data !== exp_data) begin failures++;
        $display("FAIL rr_seq%0d got valid=%b ch=%0d data=%h want 1/%0d/%h", i, rr_out_valid, rr_out_ch, rr_out_data, exp_ch, exp_data); end
      exp_ch = 2'(i / 2);
      exp_data = DW'(((i / 2) << 16) | (i % 2));
      checks++; if (fx_out_valid !== 1'b1 || fx_out_ch !== exp_ch || fx_out_data !== exp_data) begin failures++;
        $display("FAIL fx_seq%0d got valid=%b ch=%0d data=%h want 1/%0d/%h", i, fx_out_valid, fx_out_ch, fx_out_data, exp_ch, exp_data); end
      step();
    end
    checks++; if (rr_out_valid !== 1'b0 || fx_out_valid !== 1'b0) begin failures++;
      $display("FAIL arb_drained got rr=%b fx=%b want 0", rr_out_valid, fx_out_valid); end
  endtask

  task automatic test_full();
    do_reset();
    out_ready = 1'b0;
    in_valid = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      set_data(1, 32'h1000 + DW'(k));
      step();
    end
    checks++; if (rr_in_ready[1] !== 1'b0 || rr_ch_count[7:4] !== 4'd8) begin failures++;
      $display("FAIL full_state got rdy=%b cnt=%0d want 0/8", rr_in_ready[1], rr_ch_count[7:4]); end
    checks++; if (rr_stall !== 4'b0010 || fx_stall !== 4'b0010) begin failures++;
      $display("FAIL full_stall got rr=%b fx=%b want 0010", rr_stall, fx_stall); end
    checks++; if (rr_out_data !== 32'h1000) begin failures++;
      $display("FAIL full_head got %h want 00001000", rr_out_data); end
    set_data(1, 32'h100A);
    out_ready = 1'b1;
    step();
    in_valid = 4'h0;
    checks++; if (rr_ch_count[7:4] !== 4'd7 || rr_in_ready[1] !== 1'b1 || rr_out_data !== 32'h1001) begin failures++;
      $display("FAIL full_pop got cnt=%0d rdy=%b data=%h want 7/1/00001001", rr_ch_count[7:4], rr_in_ready[1], rr_out_data); end
    for (int k = 1; k <= 8; k++) begin
      checks++; if (rr_out_valid !== 1'b1 || rr_out_data !== 32'h1000 + DW'(k)) begin failures++;
        $display("FAIL full_drain%0d got valid=%b data=%h want 1/%h", k, rr_out_valid, rr_out_data, 32'h1000 + DW'(k)); end
      step();
    end
    checks++; if (rr_out_valid !== 1'b0 || fx_out_valid !== 1'b0) begin failures++;
      $display("FAIL full_end got rr=%b fx=%b want 0", rr_out_valid, fx_out_valid); end
  endtask

  task automatic test_hold_flush();
    out_ready = 1'b0;
    set_data(0, 32'h0000_00C0);
    set_data(3, 32'h0000_00C3);
    in_valid = 4'b1001;
    step();
    in_valid = 4'h0;
    step();
    // RR pointer is at ch1 from the previous drain, so ch3 is found before ch0.
    checks++; if (rr_out_valid !== 1'b1 || rr_out_ch !== 2'd3 || rr_out_data !== 32'hC3) begin failures++;
      $display("FAIL hold_rr_load got valid=%b ch=%0d data=%h want 1/3/c3", rr_out_valid, rr_out_ch, rr_out_data); end
    checks++; if (fx_out_ch !== 2'd0 || fx_out_data !== 32'hC0) begin failures++;
      $display("FAIL hold_fx_load got ch=%0d data=%h want 0/c0", fx_out_ch, fx_out_data); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (rr_out_valid !== 1'b1 || rr_out_ch !== 2'd3 || rr_out_data !== 32'hC3) begin failures++;
        $display("FAIL hold_stable%0d got valid=%b ch=%0d data=%h want 1/3/c3", i, rr_out_valid, rr_out_ch, rr_out_data); end
    end
    checks++; if (rr_ch_count !== 16'h0001 || rr_stall !== 4'b0010) begin failures++;
      $display("FAIL preflush got cnt=%h stall=%b want 0001/0010", rr_ch_count, rr_stall); end
    flush = 1'b1;
    in_valid = 4'b0010;
    set_data(1, 32'hDEAD_0001);
    #1;
    checks++; if (rr_in_ready !== 4'hF) begin failures++;
      $display("FAIL flush_in_ready got %h want f", rr_in_ready); end
    step();
    flush = 1'b0;
    in_valid = 4'h0;
    checks++; if (rr_out_valid !== 1'b0 || fx_out_valid !== 1'b0 || rr_out_data !== 32'h0) begin failures++;
      $display("FAIL flush_out got rr=%b fx=%b data=%h want 0/0/0", rr_out_valid, fx_out_valid, rr_out_data); end
    checks++; if (rr_ch_count !== 16'h0 || fx_ch_count !== 16'h0) begin failures++;
      $display("FAIL flush_count got rr=%h fx=%h want 0", rr_ch_count, fx_ch_count); end
    checks++; if (rr_stall !== 4'h0 || fx_stall !== 4'h0) begin failures++;
      $display("FAIL flush_stall got rr=%b fx=%b want 0", rr_stall, fx_stall); end
    step();
    checks++; if (rr_out_valid !== 1'b0 || rr_ch_count !== 16'h0) begin failures++;
      $display("FAIL flush_dropped got valid=%b cnt=%h want 0/0", rr_out_valid, rr_ch_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_arb();
    test_full();
    test_hold_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
